// File: rtl/clip_pkg.sv
// Shared types and width helpers for the clip plane/segment intersection unit.
package clip_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DOT,
      ST_DIV,
      ST_LERP,
      ST_OUT
   } clip_state_e;

   localparam int unsigned CLIP_WIDTH = 24;
   localparam int unsigned CLIP_FRAC  = 12;
   localparam int unsigned CLIP_NCOMP = 4;

   // Dot-product accumulator: 2*W product plus headroom for four terms.
   function automatic int unsigned acc_w(input int unsigned w);
      return 2 * w + 2;
   endfunction

   // Denominator d1 - d2 needs one more bit than the accumulators.
   function automatic int unsigned den_w(input int unsigned w);
      return 2 * w + 3;
   endfunction

   // Q(frac) representation of 1.0.
   function automatic int unsigned one_q(input int unsigned frac);
      return 32'd1 << frac;
   endfunction

endpackage

// File: rtl/clip_div_restoring.sv
// Restoring divider for unsigned magnitudes; yields FRAC quotient bits MSB first, one per cycle.
module clip_div_restoring #(
   parameter int unsigned DW   = 51,
   parameter int unsigned FRAC = 12
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [DW-1:0]   dividend_i,
   input  logic [DW-1:0]   divisor_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [FRAC-1:0] quo_o
);

   localparam int unsigned CW = $clog2(FRAC);

   logic [DW-1:0]   r_rem;
   logic [DW-1:0]   r_div;
   logic [FRAC-1:0] r_quo;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_done;
   logic            w_ge;
   logic [DW-1:0]   w_rem_nxt;

   // Remainder stays below the divisor, so the shifted value fits one extra bit.
   always_comb begin
      w_ge      = {r_rem, 1'b0} >= {1'b0, r_div};
      w_rem_nxt = w_ge ? DW'({r_rem, 1'b0} - {1'b0, r_div}) : DW'({r_rem, 1'b0});
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rem  <= '0;
         r_div  <= '0;
         r_quo  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start_i) begin
            r_rem  <= dividend_i;
            r_div  <= divisor_i;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_rem <= w_rem_nxt;
            r_quo <= {r_quo[FRAC-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(FRAC - 1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy_o = r_busy;
   assign done_o = r_done;
   assign quo_o  = r_quo;

endmodule

// File: rtl/clip_intersect_seq.sv
// Sequential plane/segment intersection: dot products, clamped t, per-component lerp.
// Optional CLIP_INTERSECT_EARLY_OUT_EN skips the divide phase when t is trivially known.
module clip_intersect_seq
   import clip_pkg::*;
#(
   parameter int unsigned WIDTH = CLIP_WIDTH,
   parameter int unsigned FRAC  = CLIP_FRAC,
   parameter int unsigned NCOMP = CLIP_NCOMP
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [NCOMP*WIDTH-1:0] v1_i,
   input  logic [NCOMP*WIDTH-1:0] v2_i,
   input  logic [4*WIDTH-1:0]     plane_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [NCOMP*WIDTH-1:0] p_o,
   output logic [FRAC:0]          t_o,
   output logic                   parallel_o,
   output logic                   clamped_o
);

   localparam int unsigned AW      = acc_w(WIDTH);
   localparam int unsigned DW      = den_w(WIDTH);
   localparam int unsigned MW      = WIDTH + 1;
   localparam int unsigned PW      = 2 * MW;
   localparam int unsigned TW      = FRAC + 1;
   localparam int unsigned CNT_MAX = (FRAC > NCOMP) ? FRAC : NCOMP;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam int unsigned IDX_W   = $clog2(NCOMP);
   localparam logic [TW-1:0] T_ONE = TW'(one_q(FRAC));

   clip_state_e r_state, w_state_nxt;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_in_ready, r_out_valid;
   logic signed [WIDTH-1:0] r_v1 [NCOMP];
   logic signed [WIDTH-1:0] r_v2 [NCOMP];
   logic signed [WIDTH-1:0] r_pl [4];
   logic signed [WIDTH-1:0] r_p  [NCOMP];
   logic signed [AW-1:0]    r_d1, r_d2;
   logic [TW-1:0]           r_t;
   logic                    r_par, r_clamp;

   logic [IDX_W-1:0]          w_idx;
   logic signed [MW-1:0]      w_mul_a, w_mul_b, w_diff;
   logic signed [PW-1:0]      w_mul;
   logic signed [2*WIDTH-1:0] w_prod2;
   logic signed [AW-1:0]      w_d1_sum, w_d2_sum;
   logic signed [DW-1:0]      w_num, w_den;
   logic [DW-1:0]             w_num_mag, w_den_mag;
   logic                      w_triv, w_par, w_clamp;
   logic [TW-1:0]             w_t_triv, w_t_lerp;
   logic signed [WIDTH-1:0]   w_lerp;
   logic                      w_div_start, w_div_busy, w_div_done;
   logic [FRAC-1:0]           w_quo;

   assign w_idx = r_cnt[IDX_W-1:0];

   // The d1 product path doubles as the lerp multiplier.
   always_comb begin
      w_mul_a = MW'(r_pl[r_cnt[1:0]]);
      w_mul_b = MW'(r_v1[w_idx]);
      if (r_state == ST_LERP) begin
         w_mul_a = MW'($signed({1'b0, w_t_lerp}));
         w_mul_b = w_diff;
      end
   end

   always_comb begin
      w_diff    = MW'(r_v2[w_idx]) - MW'(r_v1[w_idx]);
      w_mul     = PW'(w_mul_a) * PW'(w_mul_b);
      w_prod2   = (2*WIDTH)'(r_pl[r_cnt[1:0]]) * (2*WIDTH)'(r_v2[w_idx]);
      w_d1_sum  = r_d1 + w_mul;
      w_d2_sum  = r_d2 + AW'(w_prod2);
      w_num     = DW'(w_d1_sum);
      w_den     = DW'(w_d1_sum) - DW'(w_d2_sum);
      w_num_mag = w_num[DW-1] ? -w_num : w_num;
      w_den_mag = w_den[DW-1] ? -w_den : w_den;
      w_t_lerp  = w_div_done ? {1'b0, w_quo} : r_t;
      w_lerp    = r_v1[w_idx] + WIDTH'(w_mul >>> FRAC);
   end

   // Trivial outcomes, evaluated on the final sums during the last DOT cycle.
   always_comb begin
      w_triv   = 1'b1;
      w_par    = 1'b0;
      w_clamp  = 1'b0;
      w_t_triv = '0;
      if (w_den == '0) begin
         w_par = 1'b1;
      end else if ((w_num != '0) && (w_num[DW-1] != w_den[DW-1])) begin
         w_clamp = 1'b1;
      end else if (w_num_mag >= w_den_mag) begin
         w_t_triv = T_ONE;
         w_clamp  = (w_num != w_den);
      end else begin
         w_triv = 1'b0;
      end
   end

   assign w_div_start = (r_state == ST_DOT) && (r_cnt == CNT_W'(3)) && !w_triv && !w_div_busy;

   clip_div_restoring #(
      .DW   (DW),
      .FRAC (FRAC)
   ) u_div (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (w_div_start),
      .dividend_i (w_num_mag),
      .divisor_i  (w_den_mag),
      .busy_o     (w_div_busy),
      .done_o     (w_div_done),
      .quo_o      (w_quo)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid_i) w_state_nxt = ST_DOT;
         ST_DOT: if (r_cnt == CNT_W'(3)) begin
`ifdef CLIP_INTERSECT_EARLY_OUT_EN
            w_state_nxt = w_triv ? ST_LERP : ST_DIV;
`else
            w_state_nxt = ST_DIV;
`endif
         end
         ST_DIV:  if (r_cnt == CNT_W'(FRAC - 1)) w_state_nxt = ST_LERP;
         ST_LERP: if (r_cnt == CNT_W'(NCOMP - 1)) w_state_nxt = ST_OUT;
         ST_OUT:  if (out_ready_i) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (w_state_nxt == ST_OUT);
         if (w_state_nxt != r_state)
            r_cnt <= '0;
         else if (r_state inside {ST_DOT, ST_DIV, ST_LERP})
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NCOMP; k++) begin
            r_v1[k] <= '0;
            r_v2[k] <= '0;
            r_p[k]  <= '0;
         end
         for (int k = 0; k < 4; k++) r_pl[k] <= '0;
         r_d1    <= '0;
         r_d2    <= '0;
         r_t     <= '0;
         r_par   <= 1'b0;
         r_clamp <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (in_valid_i) begin
               for (int k = 0; k < NCOMP; k++) begin
                  r_v1[k] <= v1_i[k*WIDTH +: WIDTH];
                  r_v2[k] <= v2_i[k*WIDTH +: WIDTH];
               end
               for (int k = 0; k < 4; k++) r_pl[k] <= plane_i[k*WIDTH +: WIDTH];
               r_d1 <= '0;
               r_d2 <= '0;
            end
            ST_DOT: begin
               r_d1 <= w_d1_sum;
               r_d2 <= w_d2_sum;
               if (r_cnt == CNT_W'(3)) begin
                  r_t     <= w_t_triv;
                  r_par   <= w_par;
                  r_clamp <= w_clamp;
               end
            end
            ST_LERP: begin
               r_p[w_idx] <= w_lerp;
               r_t        <= w_t_lerp;
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < NCOMP; g++) begin : g_pout
      assign p_o[g*WIDTH +: WIDTH] = r_p[g];
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = r_out_valid;
   assign t_o         = r_t;
   assign parallel_o  = r_par;
   assign clamped_o   = r_clamp;

endmodule

// File: tb/tb_clip_intersect_seq.sv
// Randomized bench for clip_intersect_seq against an arithmetic reference of the intersection rules.
module tb_clip_intersect_seq;

   localparam int W = 24;
   localparam int F = 12;
   localparam int N = 4;

   typedef longint vec_t [N];
   typedef longint pln_t [4];

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [N*W-1:0]   v1_i = '0;
   logic [N*W-1:0]   v2_i = '0;
   logic [4*W-1:0]   plane_i = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [N*W-1:0]   p_o;
   logic [F:0]       t_o;
   logic             parallel_o;
   logic             clamped_o;

   int n_checks = 0;
   int n_fail   = 0;

   clip_intersect_seq dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .v1_i        (v1_i),
      .v2_i        (v2_i),
      .plane_i     (plane_i),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .p_o         (p_o),
      .t_o         (t_o),
      .parallel_o  (parallel_o),
      .clamped_o   (clamped_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint comp(input logic [N*W-1:0] v, input int k);
      logic signed [W-1:0] c;
      c = v[k*W +: W];
      return longint'(c);
   endfunction

   // Intersection computed directly from the rules with wide integers.
   function automatic void ref_model(input vec_t v1, input vec_t v2, input pln_t pl,
                                     output longint t, output bit par, output bit clp,
                                     output bit triv, output vec_t p);
      longint d1, d2, num, den, an, ad;
      d1 = 0;
      d2 = 0;
      for (int k = 0; k < 4; k++) begin
         d1 += pl[k] * v1[k];
         d2 += pl[k] * v2[k];
      end
      num  = d1;
      den  = d1 - d2;
      par  = 0;
      clp  = 0;
      triv = 1;
      t    = 0;
      an   = (num < 0) ? -num : num;
      ad   = (den < 0) ? -den : den;
      if (den == 0) par = 1;
      else if (num != 0 && ((num < 0) != (den < 0))) clp = 1;
      else if (an >= ad) begin
         t   = longint'(1) << F;
         clp = (num != den);
      end else begin
         t    = (an << F) / ad;
         triv = 0;
      end
      for (int k = 0; k < N; k++) p[k] = v1[k] + ((t * (v2[k] - v1[k])) >>> F);
   endfunction

   function automatic longint rnd_s(input int bits);
      longint x;
      x = longint'($urandom_range(0, (1 << bits) - 1));
      return x - (longint'(1) << (bits - 1));
   endfunction

   task automatic do_req(input string tag, input vec_t v1, input vec_t v2, input pln_t pl,
                         input int hold);
      longint et, t_snap;
      bit     ep, ec, etr;
      vec_t   epv;
      int     lat, exp_lat;
      logic [N*W-1:0] p_snap;
      ref_model(v1, v2, pl, et, ep, ec, etr, epv);
      for (int k = 0; k < N; k++) begin
         v1_i[k*W +: W] = v1[k][W-1:0];
         v2_i[k*W +: W] = v2[k][W-1:0];
      end
      for (int k = 0; k < 4; k++) plane_i[k*W +: W] = pl[k][W-1:0];
      check_val({tag, ".ready"}, longint'(in_ready), 1);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      v1_i    = {$urandom(), $urandom(), $urandom()};
      v2_i    = {$urandom(), $urandom(), $urandom()};
      plane_i = {$urandom(), $urandom(), $urandom()};
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!out_valid && lat < 100);
`ifdef CLIP_INTERSECT_EARLY_OUT_EN
      exp_lat = etr ? 4 + N : 4 + F + N;
`else
      exp_lat = 4 + F + N;
`endif
      check_val({tag, ".latency"}, lat, exp_lat);
      check_val({tag, ".t"}, longint'(t_o), et);
      check_val({tag, ".parallel"}, longint'(parallel_o), longint'(ep));
      check_val({tag, ".clamped"}, longint'(clamped_o), longint'(ec));
      for (int k = 0; k < N; k++)
         check_val($sformatf("%s.p%0d", tag, k), comp(p_o, k), epv[k]);
      t_snap = longint'(t_o);
      p_snap = p_o;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         @(posedge clk); #1;
         check_val({tag, ".hold_valid"}, longint'(out_valid), 1);
         check_val({tag, ".hold_ready"}, longint'(in_ready), 0);
         check_val({tag, ".hold_t"}, longint'(t_o), t_snap);
         check_val({tag, ".hold_p"}, longint'(p_o == p_snap), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val({tag, ".post_valid"}, longint'(out_valid), 0);
      check_val({tag, ".post_ready"}, longint'(in_ready), 1);
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, ".in_ready"}, longint'(in_ready), 1);
      check_val({tag, ".out_valid"}, longint'(out_valid), 0);
      check_val({tag, ".t"}, longint'(t_o), 0);
      check_val({tag, ".flags"}, longint'({parallel_o, clamped_o}), 0);
      check_val({tag, ".p"}, longint'(|p_o), 0);
   endtask

   initial begin
      vec_t v1, v2;
      pln_t pl;
      int   seen;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst_n = 1'b1;

      pl = '{4096, 0, 0, 0};
      v1 = '{-4096, 0, 0, 4096};
      v2 = '{4096, 8192, 0, 4096};
      do_req("half", v1, v2, pl, 0);
      check_val("half.t_const", longint'(t_o), 2048);

      v1 = '{-4096, 0, 0, 4096};
      v2 = '{8192, 0, 0, 4096};
      do_req("third", v1, v2, pl, 0);
      check_val("third.px_const", comp(p_o, 0), -1);

      v1 = '{4096, 100, -200, 4096};
      v2 = '{4096, 300, 500, 4096};
      do_req("parallel", v1, v2, pl, 0);

      v1 = '{4096, 100, -200, 4096};
      v2 = '{8192, 300, 500, 4096};
      do_req("mismatch", v1, v2, pl, 0);

      v1 = '{8192, 100, -200, 4096};
      v2 = '{4096, 300, 500, 4096};
      do_req("beyond", v1, v2, pl, 5);

      v1 = '{4096, 7, 9, 4096};
      v2 = '{0, 11, 13, 4096};
      do_req("exact_one", v1, v2, pl, 2);

      // Abort in the middle of the divide phase.
      v1 = '{-4096, 0, 0, 4096};
      v2 = '{4096, 8192, 0, 4096};
      for (int k = 0; k < N; k++) begin
         v1_i[k*W +: W] = v1[k][W-1:0];
         v2_i[k*W +: W] = v2[k][W-1:0];
      end
      for (int k = 0; k < 4; k++) plane_i[k*W +: W] = pl[k][W-1:0];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_state("midreset");
      rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check_val("midreset.no_output", seen, 0);
      check_val("midreset.ready", longint'(in_ready), 1);

      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < N; k++) begin
            v1[k] = rnd_s((i % 3 == 0) ? 16 : 24);
            v2[k] = (i % 7 == 3) ? v1[k] : rnd_s(24);
         end
         for (int k = 0; k < 4; k++) pl[k] = (i % 5 == 1 && k > 0) ? 0 : rnd_s(24);
         do_req($sformatf("rnd%0d", i), v1, v2, pl, int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
